shot_clock_controller: RTL and testbench

Sequences the scoreboard's timing datapath: a shot countdown of 24 or 14 s and a game clock in mm:ss per period, plus period count and buzzers. Advances only on a 1 Hz enable pulse from the prescaler. Front-panel button pulses drive start/stop, shot reloads and period advance. Outputs feed the 7-segment display drivers and the buzzer driver.

---
 rtl/shot_clock_controller.sv | 194 +++++++++++++++++++
 tb/tb_shot_clock_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_clock_controller.sv
// Shot clock / game clock sequencer for the scoreboard timing datapath.
// Ports:
//   clock_in, reset_n    - system clock, async active-low reset
//   tick_1hz             - one-cycle enable pulse once per second
//   btn_start_stop       - toggle run/pause
//   btn_shot_24/_14      - shot clock reloads (full / conditional short)
//   btn_next_period      - advance once a period has ended
//   shot_count           - shot clock seconds
//   game_min, game_sec   - game clock mm:ss
//   period               - current period, 1-based
//   running, game_over   - state flags
//   shot_buzzer, game_buzzer - buzzer drives
module shot_clock_controller #(
    parameter int unsigned SHOT_FULL   = 24,
    parameter int unsigned SHOT_SHORT  = 14,
    parameter int unsigned PERIOD_MIN  = 10,
    parameter int unsigned NUM_PERIODS = 4,
    parameter int unsigned BUZZ_TICKS  = 3
) (
    input  logic       clock_in,
    input  logic       reset_n,
    input  logic       tick_1hz,
    input  logic       btn_start_stop,
    input  logic       btn_shot_24,
    input  logic       btn_shot_14,
    input  logic       btn_next_period,
    output logic [4:0] shot_count,
    output logic [3:0] game_min,
    output logic [5:0] game_sec,
    output logic [2:0] period,
    output logic       running,
    output logic       shot_buzzer,
    output logic       game_buzzer,
    output logic       game_over
);

    localparam int unsigned SHOT_W = 5;
    localparam int unsigned MIN_W  = 4;
    localparam int unsigned SEC_W  = 6;
    localparam int unsigned PER_W  = 3;
    localparam int unsigned BUZZ_W = (BUZZ_TICKS < 2) ? 1 : $clog2(BUZZ_TICKS + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_SHOT_EXP,
        ST_PERIOD_END,
        ST_GAME_OVER
    } state_e;

    state_e              state_q, state_d;
    logic [SHOT_W-1:0]   shot_q, shot_d;
    logic [MIN_W-1:0]    min_q, min_d;
    logic [SEC_W-1:0]    sec_q, sec_d;
    logic [PER_W-1:0]    period_q, period_d;
    logic [BUZZ_W-1:0]   sbuz_cnt_q, sbuz_cnt_d;
    logic [BUZZ_W-1:0]   gbuz_cnt_q, gbuz_cnt_d;
    logic                running_q, running_d;
    logic                sbuz_q, sbuz_d;
    logic                gbuz_q, gbuz_d;
    logic                game_over_q, game_over_d;

    logic                reload_en;
    logic [MIN_W-1:0]    dec_min;
    logic [SEC_W-1:0]    dec_sec;
    logic                dec_zero;

    // Game clock one second earlier, saturating at 00:00.
    always_comb begin
        dec_min = min_q;
        dec_sec = sec_q;
        if (sec_q != '0) begin
            dec_sec = sec_q - SEC_W'(1);
        end else if (min_q != '0) begin
            dec_sec = SEC_W'(59);
            dec_min = min_q - MIN_W'(1);
        end
        dec_zero = (dec_min == '0) && (dec_sec == '0);
    end

    // Reload accepted outside PERIOD_END/GAME_OVER; short reload only shortens.
    always_comb begin
        reload_en = ((state_q == ST_IDLE) || (state_q == ST_RUN) ||
                     (state_q == ST_PAUSE) || (state_q == ST_SHOT_EXP)) &&
                    (btn_shot_24 || (btn_shot_14 && (shot_q < SHOT_W'(SHOT_SHORT))));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        shot_d     = shot_q;
        min_d      = min_q;
        sec_d      = sec_q;
        period_d   = period_q;
        sbuz_cnt_d = sbuz_cnt_q;
        gbuz_cnt_d = gbuz_cnt_q;

        // Buzzers count down on every tick regardless of state.
        if (tick_1hz && (sbuz_cnt_q != '0)) sbuz_cnt_d = sbuz_cnt_q - BUZZ_W'(1);
        if (tick_1hz && (gbuz_cnt_q != '0)) gbuz_cnt_d = gbuz_cnt_q - BUZZ_W'(1);

        unique case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (btn_start_stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tick_1hz) begin
                    min_d = dec_min;
                    sec_d = dec_sec;
                    // Period end wins over shot expiry; shot clock is left as is.
                    if (dec_zero) begin
                        state_d    = ST_PERIOD_END;
                        gbuz_cnt_d = BUZZ_W'(BUZZ_TICKS);
                    end else if (!reload_en && (shot_q != '0)) begin
                        shot_d = shot_q - SHOT_W'(1);
                        if (shot_q == SHOT_W'(1)) begin
                            state_d    = ST_SHOT_EXP;
                            sbuz_cnt_d = BUZZ_W'(BUZZ_TICKS);
                        end
                    end
                end
                if (btn_start_stop && (state_d == ST_RUN)) state_d = ST_PAUSE;
            end
            ST_SHOT_EXP: begin
                if (reload_en) state_d = ST_PAUSE;
            end
            ST_PERIOD_END: begin
                if (btn_next_period) begin
                    if (period_q < PER_W'(NUM_PERIODS)) begin
                        period_d = period_q + PER_W'(1);
                        min_d    = MIN_W'(PERIOD_MIN);
                        sec_d    = '0;
                        shot_d   = SHOT_W'(SHOT_FULL);
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_GAME_OVER;
                    end
                end
            end
            default: ;
        endcase

        // Reload overrides any shot decrement and silences the shot buzzer.
        if (reload_en) begin
            shot_d     = btn_shot_24 ? SHOT_W'(SHOT_FULL) : SHOT_W'(SHOT_SHORT);
            sbuz_cnt_d = '0;
        end

        running_d   = (state_d == ST_RUN);
        game_over_d = (state_d == ST_GAME_OVER);
        sbuz_d      = (sbuz_cnt_d != '0);
        gbuz_d      = (gbuz_cnt_d != '0);
    end

    // State and output registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            shot_q      <= SHOT_W'(SHOT_FULL);
            min_q       <= MIN_W'(PERIOD_MIN);
            sec_q       <= '0;
            period_q    <= PER_W'(1);
            sbuz_cnt_q  <= '0;
            gbuz_cnt_q  <= '0;
            running_q   <= 1'b0;
            sbuz_q      <= 1'b0;
            gbuz_q      <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shot_q      <= shot_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            period_q    <= period_d;
            sbuz_cnt_q  <= sbuz_cnt_d;
            gbuz_cnt_q  <= gbuz_cnt_d;
            running_q   <= running_d;
            sbuz_q      <= sbuz_d;
            gbuz_q      <= gbuz_d;
            game_over_q <= game_over_d;
        end
    end

    assign shot_count  = shot_q;
    assign game_min    = min_q;
    assign game_sec    = sec_q;
    assign period      = period_q;
    assign running     = running_q;
    assign shot_buzzer = sbuz_q;
    assign game_buzzer = gbuz_q;
    assign game_over   = game_over_q;

endmodule

// File: tb/tb_shot_clock_controller.sv
// Self-checking bench for shot_clock_controller: directed scenarios plus
// randomized button/tick traffic against a seconds-based reference model.
module tb_shot_clock_controller;

    localparam int SF = 24;
    localparam int SS = 14;
    localparam int PM = 10;
    localparam int NP = 4;
    localparam int BT = 3;

    localparam int MD_IDLE  = 0;
    localparam int MD_RUN   = 1;
    localparam int MD_PAUSE = 2;
    localparam int MD_SEXP  = 3;
    localparam int MD_PEND  = 4;
    localparam int MD_OVER  = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz, btn_start_stop, btn_shot_24, btn_shot_14, btn_next_period;
    logic [4:0] shot_count;
    logic [3:0] game_min;
    logic [5:0] game_sec;
    logic [2:0] period;
    logic       running, shot_buzzer, game_buzzer, game_over;

    int checks = 0;
    int errors = 0;

    // Reference model: game time kept as total seconds, buzzers as remaining ticks.
    int m_mode, m_shot, m_g, m_per, m_sbz, m_gbz;

    always #5 clk = ~clk;

    shot_clock_controller dut (
        .clock_in        (clk),
        .reset_n         (rst_n),
        .tick_1hz        (tick_1hz),
        .btn_start_stop  (btn_start_stop),
        .btn_shot_24     (btn_shot_24),
        .btn_shot_14     (btn_shot_14),
        .btn_next_period (btn_next_period),
        .shot_count      (shot_count),
        .game_min        (game_min),
        .game_sec        (game_sec),
        .period          (period),
        .running         (running),
        .shot_buzzer     (shot_buzzer),
        .game_buzzer     (game_buzzer),
        .game_over       (game_over)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_shot"},   32'(shot_count),  32'(m_shot));
        chk({tag, "_min"},    32'(game_min),    32'(m_g / 60));
        chk({tag, "_sec"},    32'(game_sec),    32'(m_g % 60));
        chk({tag, "_period"}, 32'(period),      32'(m_per));
        chk({tag, "_run"},    32'(running),     32'(m_mode == MD_RUN));
        chk({tag, "_sbuz"},   32'(shot_buzzer), 32'(m_sbz > 0));
        chk({tag, "_gbuz"},   32'(game_buzzer), 32'(m_gbz > 0));
        chk({tag, "_over"},   32'(game_over),   32'(m_mode == MD_OVER));
    endtask

    task automatic model_reset();
        m_mode = MD_IDLE;
        m_shot = SF;
        m_g    = PM * 60;
        m_per  = 1;
        m_sbz  = 0;
        m_gbz  = 0;
    endtask

    task automatic model_step(input bit t, input bit ss, input bit b24, input bit b14, input bit np);
        int  nm    = m_mode;
        int  nshot = m_shot;
        int  ng    = m_g;
        int  nper  = m_per;
        int  nsbz  = m_sbz;
        int  ngbz  = m_gbz;
        bit  rl;
        rl = (m_mode == MD_IDLE || m_mode == MD_RUN || m_mode == MD_PAUSE || m_mode == MD_SEXP)
             && (b24 || (b14 && m_shot < SS));
        if (t && m_sbz > 0) nsbz = m_sbz - 1;
        if (t && m_gbz > 0) ngbz = m_gbz - 1;
        case (m_mode)
            MD_IDLE, MD_PAUSE: if (ss) nm = MD_RUN;
            MD_RUN: begin
                if (t) begin
                    ng = (m_g > 0) ? m_g - 1 : 0;
                    if (ng == 0) begin
                        nm   = MD_PEND;
                        ngbz = BT;
                    end else if (!rl && m_shot > 0) begin
                        nshot = m_shot - 1;
                        if (nshot == 0) begin
                            nm   = MD_SEXP;
                            nsbz = BT;
                        end
                    end
                end
                if (ss && nm == MD_RUN) nm = MD_PAUSE;
            end
            MD_SEXP: if (rl) nm = MD_PAUSE;
            MD_PEND: if (np) begin
                if (m_per < NP) begin
                    nper  = m_per + 1;
                    ng    = PM * 60;
                    nshot = SF;
                    nm    = MD_IDLE;
                end else begin
                    nm = MD_OVER;
                end
            end
            default: ;
        endcase
        if (rl) begin
            nshot = b24 ? SF : SS;
            nsbz  = 0;
        end
        m_mode = nm; m_shot = nshot; m_g = ng; m_per = nper; m_sbz = nsbz; m_gbz = ngbz;
    endtask

    // One clock: drive pulses at negedge, check #1 after the rising edge.
    task automatic cycle(input bit t, input bit ss, input bit b24, input bit b14, input bit np,
                         input string tag);
        @(negedge clk);
        tick_1hz = t; btn_start_stop = ss; btn_shot_24 = b24; btn_shot_14 = b14;
        btn_next_period = np;
        model_step(t, ss, b24, b14, np);
        @(posedge clk);
        #1;
        check_all(tag);
        tick_1hz = 0; btn_start_stop = 0; btn_shot_24 = 0; btn_shot_14 = 0; btn_next_period = 0;
    endtask

    // Play the game clock down to zero, keeping the shot clock alive.
    task automatic run_to_pend(input string tag);
        for (int i = 0; i < 4000 && m_mode != MD_PEND; i++) begin
            if (m_mode == MD_SEXP)     cycle(0, 0, 1, 0, 0, tag);
            else if (m_mode == MD_RUN) cycle(1, 0, m_shot <= 2, 0, 0, tag);
            else                       cycle(0, 1, 0, 0, 0, tag);
        end
        chk({tag, "_end_min"}, 32'(game_min), 32'd0);
        chk({tag, "_end_sec"}, 32'(game_sec), 32'd0);
        chk({tag, "_end_run"}, 32'(running),  32'd0);
    endtask

    task automatic random_phase(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0, tag);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick_1hz = 0; btn_start_stop = 0; btn_shot_24 = 0; btn_shot_14 = 0; btn_next_period = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Start and five seconds of play.
        cycle(0, 1, 0, 0, 0, "start");
        repeat (5) cycle(1, 0, 0, 0, 0, "t1");
        chk("t1_shot19", 32'(shot_count), 32'd19);
        chk("t1_min9",   32'(game_min),   32'd9);
        chk("t1_sec55",  32'(game_sec),   32'd55);
        chk("t1_run",    32'(running),    32'd1);

        // Shot expiry, buzzer duration, frozen game clock, short reload exit.
        repeat (18) cycle(1, 0, 0, 0, 0, "t2a");
        chk("t2_shot1", 32'(shot_count), 32'd1);
        cycle(1, 0, 0, 0, 0, "t2exp");
        chk("t2_shot0", 32'(shot_count), 32'd0);
        chk("t2_sbuz",  32'(shot_buzzer), 32'd1);
        cycle(1, 0, 0, 0, 0, "t2b1");
        cycle(1, 0, 0, 0, 0, "t2b2");
        chk("t2_sbuz_still", 32'(shot_buzzer), 32'd1);
        cycle(1, 0, 0, 0, 0, "t2b3");
        chk("t2_sbuz_off", 32'(shot_buzzer), 32'd0);
        chk("t2_frozen_sec", 32'(game_sec), 32'd36);
        cycle(0, 1, 0, 0, 0, "t2ss_ign");
        cycle(0, 0, 0, 1, 0, "t2r14");
        chk("t2_shot14", 32'(shot_count), 32'd14);

        // Short-reload condition and reload priority.
        cycle(0, 1, 0, 0, 0, "t3run");
        cycle(0, 0, 1, 0, 0, "t3r24");
        repeat (4) cycle(1, 0, 0, 0, 0, "t3a");
        cycle(0, 0, 0, 1, 0, "t3r14_no");
        chk("t3_shot20", 32'(shot_count), 32'd20);
        repeat (10) cycle(1, 0, 0, 0, 0, "t3b");
        cycle(0, 0, 0, 1, 0, "t3r14_yes");
        chk("t3_shot14", 32'(shot_count), 32'd14);
        cycle(1, 0, 1, 1, 0, "t3both");
        chk("t3_shot24", 32'(shot_count), 32'd24);

        // Period end beats shot expiry at 0:01 / shot 1.
        for (int i = 0; i < 2000 && m_g != 25; i++) cycle(1, 0, m_shot <= 2, 0, 0, "t4a");
        cycle(1, 0, 1, 0, 0, "t4load");
        repeat (23) cycle(1, 0, 0, 0, 0, "t4b");
        chk("t4_shot1", 32'(shot_count), 32'd1);
        chk("t4_sec1",  32'(game_sec),   32'd1);
        cycle(1, 0, 0, 0, 0, "t4pend");
        chk("t4_gbuz", 32'(game_buzzer), 32'd1);
        chk("t4_sbuz", 32'(shot_buzzer), 32'd0);
        cycle(0, 1, 1, 0, 0, "t4ign");
        cycle(0, 0, 0, 0, 1, "t4next");
        chk("t4_period2", 32'(period),     32'd2);
        chk("t4_min10",   32'(game_min),   32'd10);
        chk("t4_shot24",  32'(shot_count), 32'd24);

        // Play out to the final period and game over.
        run_to_pend("p2");
        cycle(0, 0, 0, 0, 1, "p2next");
        run_to_pend("p3");
        cycle(0, 0, 0, 0, 1, "p3next");
        run_to_pend("p4");
        chk("p4_period", 32'(period), 32'd4);
        cycle(0, 0, 0, 0, 1, "over");
        chk("over_flag", 32'(game_over), 32'd1);
        random_phase(40, "frozen");
        chk("frozen_period", 32'(period), 32'd4);

        // Async reset taking effect between clock edges.
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all("rst_over");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 1, 0, 0, 0, "r2start");
        repeat (7) cycle(1, 0, 0, 0, 0, "r2run");
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all("rst_async");
        chk("rst_async_shot", 32'(shot_count), 32'd24);
        @(negedge clk);
        rst_n = 1'b1;

        random_phase(3000, "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
